audio_sample_buffer: RTL and testbench

Buffers stereo PCM samples arriving on the pixel clock and presents them, one per pop, to the audio sample packet stage. Sits directly upstream of the audio sample packet generator. It supplies the 24-bit left-justified sample words, the IEC 60958 frame index (0–191), and the per-channel valid/user bits. The packet scheduler pops one sample per audio sample packet it emits.

---
 rtl/hdmi_audio_pkg.sv | 14 +
 rtl/audio_sample_fifo.sv | 69 ++++++
 rtl/audio_sample_buffer.sv | 105 ++++++++++
 tb/tb_audio_sample_buffer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_audio_pkg.sv
// Shared types and constants for the HDMI audio sample path.
package hdmi_audio_pkg;

   localparam int unsigned AUDIO_WORD_WIDTH      = 24;
   localparam int unsigned IEC60958_BLOCK_FRAMES = 192;

   typedef logic [AUDIO_WORD_WIDTH-1:0] audio_word_t;

   typedef struct packed {
      audio_word_t left;
      audio_word_t right;
   } stereo_sample_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Generic single-clock FIFO of stereo samples with occupancy count, full and empty flags.
// Head entry is read straight from the storage array, so the head is visible the cycle
// after it is written.
module audio_sample_fifo
   import hdmi_audio_pkg::*;
#(
   parameter int unsigned Depth = 8,
   localparam int unsigned PtrW = $clog2(Depth)
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           push_i,
   input  stereo_sample_t wdata_i,
   input  logic           pop_i,
   output stereo_sample_t rdata_o,
   output logic [PtrW:0]  count_o,
   output logic           full_o,
   output logic           empty_o
);

   localparam logic [PtrW:0] DepthCount = (PtrW+1)'(Depth);

   stereo_sample_t mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   count_q, count_d;
   logic            push_ok, pop_ok;

   assign full_o  = (count_q == DepthCount);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Next-state for pointers and occupancy; pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (PtrW+1)'(1);
         2'b01:   count_d = count_q - (PtrW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Sample storage; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/audio_sample_buffer.sv
// Stereo PCM sample buffer feeding the audio sample packet generator. Formats samples to
// MSB-aligned 24-bit words on write, tracks the IEC 60958 frame index of the head sample
// and counts pops requested while empty.
module audio_sample_buffer
   import hdmi_audio_pkg::*;
#(
   parameter int unsigned AUDIO_BIT_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH      = 8
) (
   input  logic                       clk_pixel,
   input  logic                       reset_n,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   input  logic [AUDIO_BIT_WIDTH-1:0] sample_left,
   input  logic [AUDIO_BIT_WIDTH-1:0] sample_right,
   input  logic                       pkt_request,
   output logic                       pkt_valid,
   output audio_word_t [1:0]          audio_sample_word,
   output logic [7:0]                 frame_counter,
   output logic [1:0]                 valid_bit,
   output logic [1:0]                 user_data_bit,
   output logic [15:0]                underflow_count
);

   localparam int unsigned CountW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CountW-1:0] DepthCount = CountW'(FIFO_DEPTH);
   localparam logic [7:0] LastFrame = 8'(IEC60958_BLOCK_FRAMES - 1);

   stereo_sample_t    wr_sample, head_sample;
   stereo_sample_t    last_q, last_d;
   logic [CountW-1:0] fifo_count;
   logic              fifo_full, fifo_empty;
   logic              push, pop, underflow;
   logic [7:0]        frame_q, frame_d;
   logic [15:0]       underflow_q, underflow_d;

   // MSB-align each sample into a 24-bit word at write time.
   always_comb begin
      wr_sample = '0;
      wr_sample.left[AUDIO_WORD_WIDTH-1 -: AUDIO_BIT_WIDTH]  = sample_left;
      wr_sample.right[AUDIO_WORD_WIDTH-1 -: AUDIO_BIT_WIDTH] = sample_right;
   end

   // Ready comes only from registered occupancy and reset, never from pkt_request.
   assign sample_ready = reset_n && !fifo_full;
   assign pkt_valid    = !fifo_empty;
   assign push         = sample_valid && sample_ready;
   assign pop          = pkt_request && pkt_valid;
   assign underflow    = pkt_request && !pkt_valid;

   audio_sample_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_pixel),
      .rst_ni  (reset_n),
      .push_i  (push),
      .wdata_i (wr_sample),
      .pop_i   (pop),
      .rdata_o (head_sample),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Next-state for frame index, underflow counter and last-popped hold value.
   always_comb begin
      frame_d     = frame_q;
      underflow_d = underflow_q;
      last_d      = last_q;
      if (pop) begin
         frame_d = (frame_q == LastFrame) ? 8'd0 : frame_q + 8'd1;
         last_d  = head_sample;
      end
      if (underflow && (underflow_q != 16'hFFFF)) underflow_d = underflow_q + 16'd1;
   end

   // State registers; reset flushes everything and restarts the IEC block.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         frame_q     <= '0;
         underflow_q <= '0;
         last_q      <= '0;
      end else begin
         frame_q     <= frame_d;
         underflow_q <= underflow_d;
         last_q      <= last_d;
      end
   end

   // When empty, keep presenting the last popped sample rather than stale storage.
   always_comb begin
      audio_sample_word[0] = pkt_valid ? head_sample.left  : last_q.left;
      audio_sample_word[1] = pkt_valid ? head_sample.right : last_q.right;
   end

   assign frame_counter   = frame_q;
   assign underflow_count = underflow_q;
   assign valid_bit       = 2'b00;
   assign user_data_bit   = 2'b00;

   // Occupancy can never exceed the configured depth.
   occupancy_bound : assert property (@(posedge clk_pixel) disable iff (!reset_n)
      fifo_count <= DepthCount);

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Directed bench for audio_sample_buffer: a 16-bit instance and a 24-bit instance.
module tb_audio_sample_buffer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sample_valid, sample_ready, pkt_request, pkt_valid;
   logic [15:0] sample_left, sample_right;
   logic [1:0][23:0] audio_sample_word;
   logic [7:0]  frame_counter;
   logic [1:0]  valid_bit, user_data_bit;
   logic [15:0] underflow_count;

   logic        v24, ready24, req24, pv24;
   logic [23:0] l24, r24;
   logic [1:0][23:0] word24;
   logic [7:0]  frame24;
   logic [1:0]  vb24, ub24;
   logic [15:0] uf24;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   audio_sample_buffer #(.AUDIO_BIT_WIDTH(16), .FIFO_DEPTH(8)) dut (
      .clk_pixel         (clk),
      .reset_n           (reset_n),
      .sample_valid      (sample_valid),
      .sample_ready      (sample_ready),
      .sample_left       (sample_left),
      .sample_right      (sample_right),
      .pkt_request       (pkt_request),
      .pkt_valid         (pkt_valid),
      .audio_sample_word (audio_sample_word),
      .frame_counter     (frame_counter),
      .valid_bit         (valid_bit),
      .user_data_bit     (user_data_bit),
      .underflow_count   (underflow_count)
   );

   audio_sample_buffer #(.AUDIO_BIT_WIDTH(24), .FIFO_DEPTH(8)) dut24 (
      .clk_pixel         (clk),
      .reset_n           (reset_n),
      .sample_valid      (v24),
      .sample_ready      (ready24),
      .sample_left       (l24),
      .sample_right      (r24),
      .pkt_request       (req24),
      .pkt_valid         (pv24),
      .audio_sample_word (word24),
      .frame_counter     (frame24),
      .valid_bit         (vb24),
      .user_data_bit     (ub24),
      .underflow_count   (uf24)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      sample_valid = 0; pkt_request = 0; sample_left = '0; sample_right = '0;
      v24 = 0; req24 = 0; l24 = '0; r24 = '0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      reset_n = 1'b0;
      step();
      checks++; if (pkt_valid !== 1'b0) begin errors++;
         $display("FAIL reset_pkt_valid: got %0b expected 0", pkt_valid); end
      checks++; if (sample_ready !== 1'b0) begin errors++;
         $display("FAIL reset_ready: got %0b expected 0", sample_ready); end
      checks++; if (frame_counter !== 8'd0) begin errors++;
         $display("FAIL reset_frame: got %0d expected 0", frame_counter); end
      checks++; if (underflow_count !== 16'd0) begin errors++;
         $display("FAIL reset_underflow: got %0d expected 0", underflow_count); end
      checks++; if (audio_sample_word !== 48'd0) begin errors++;
         $display("FAIL reset_word: got %h expected 0", audio_sample_word); end
      checks++; if ({valid_bit, user_data_bit} !== 4'b0000) begin errors++;
         $display("FAIL reset_status_bits: got %b expected 0000", {valid_bit, user_data_bit}); end
      reset_n = 1'b1;
      #1;
      checks++; if (sample_ready !== 1'b1) begin errors++;
         $display("FAIL release_ready: got %0b expected 1", sample_ready); end
      step();
   endtask

   task automatic test_single();
      do_reset();
      sample_valid = 1; sample_left = 16'h1234; sample_right = 16'hABCD;
      step();
      sample_valid = 0;
      checks++; if (pkt_valid !== 1'b1) begin errors++;
         $display("FAIL single_valid: got %0b expected 1", pkt_valid); end
      checks++; if (audio_sample_word[0] !== 24'h123400) begin errors++;
         $display("FAIL single_left: got %h expected 123400", audio_sample_word[0]); end
      checks++; if (audio_sample_word[1] !== 24'hABCD00) begin errors++;
         $display("FAIL single_right: got %h expected abcd00", audio_sample_word[1]); end
      checks++; if (frame_counter !== 8'd0) begin errors++;
         $display("FAIL single_frame: got %0d expected 0", frame_counter); end
      pkt_request = 1;
      step();
      pkt_request = 0;
      checks++; if (pkt_valid !== 1'b0) begin errors++;
         $display("FAIL single_pop_empty: got %0b expected 0", pkt_valid); end
      checks++; if (frame_counter !== 8'd1) begin errors++;
         $display("FAIL single_pop_frame: got %0d expected 1", frame_counter); end
      checks++; if (audio_sample_word[0] !== 24'h123400) begin errors++;
         $display("FAIL single_hold: got %h expected 123400", audio_sample_word[0]); end
   endtask

   task automatic test_full();
      logic [15:0] el;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         sample_valid = 1; sample_left = 16'h1000 + 16'(i); sample_right = 16'h2000 + 16'(i);
         checks++; if (sample_ready !== 1'b1) begin errors++;
            $display("FAIL full_fill_ready[%0d]: got %0b expected 1", i, sample_ready); end
         step();
      end
      sample_left = 16'h1008; sample_right = 16'h2008;
      checks++; if (sample_ready !== 1'b0) begin errors++;
         $display("FAIL full_ready_drop: got %0b expected 0", sample_ready); end
      step();
      checks++; if (sample_ready !== 1'b0) begin errors++;
         $display("FAIL full_held_off: got %0b expected 0", sample_ready); end
      checks++; if (audio_sample_word[0] !== 24'h100000) begin errors++;
         $display("FAIL full_head: got %h expected 100000", audio_sample_word[0]); end
      pkt_request = 1;
      step();
      pkt_request = 0;
      checks++; if (sample_ready !== 1'b1) begin errors++;
         $display("FAIL full_ready_after_pop: got %0b expected 1", sample_ready); end
      checks++; if (audio_sample_word[0] !== 24'h100100) begin errors++;
         $display("FAIL full_head_after_pop: got %h expected 100100", audio_sample_word[0]); end
      step();
      sample_valid = 0;
      checks++; if (sample_ready !== 1'b0) begin errors++;
         $display("FAIL full_ninth_accepted: got %0b expected 0", sample_ready); end
      for (int i = 1; i <= 8; i++) begin
         el = 16'h1000 + 16'(i);
         checks++; if (pkt_valid !== 1'b1 || audio_sample_word[0] !== {el, 8'h00}
                       || audio_sample_word[1] !== {el + 16'h1000, 8'h00}) begin errors++;
            $display("FAIL full_drain[%0d]: got v=%0b %h expected v=1 %h%h", i, pkt_valid,
                     audio_sample_word, {el + 16'h1000, 8'h00}, {el, 8'h00}); end
         checks++; if (frame_counter !== 8'(i)) begin errors++;
            $display("FAIL full_drain_frame[%0d]: got %0d expected %0d", i, frame_counter, i); end
         pkt_request = 1;
         step();
         pkt_request = 0;
      end
      checks++; if (pkt_valid !== 1'b0) begin errors++;
         $display("FAIL full_drained: got %0b expected 0", pkt_valid); end
   endtask

   task automatic test_stream();
      logic [15:0] el, er;
      do_reset();
      sample_valid = 1; sample_left = 16'd5; sample_right = 16'hFFFF;
      step();
      for (int i = 1; i <= 400; i++) begin
         if (i == 400) sample_valid = 0;
         sample_left = 16'(i * 37 + 5); sample_right = 16'(65535 - i);
         pkt_request = 1;
         el = 16'((i - 1) * 37 + 5); er = 16'(65535 - (i - 1));
         checks++; if (audio_sample_word[0] !== {el, 8'h00}
                       || audio_sample_word[1] !== {er, 8'h00}) begin errors++;
            $display("FAIL stream_data[%0d]: got %h expected %h%h", i - 1, audio_sample_word,
                     {er, 8'h00}, {el, 8'h00}); end
         checks++; if (frame_counter !== 8'((i - 1) % 192)) begin errors++;
            $display("FAIL stream_frame[%0d]: got %0d expected %0d", i - 1, frame_counter,
                     (i - 1) % 192); end
         step();
      end
      pkt_request = 0;
      checks++; if (pkt_valid !== 1'b0 || frame_counter !== 8'd16) begin errors++;
         $display("FAIL stream_end: got v=%0b frame=%0d expected v=0 frame=16", pkt_valid,
                  frame_counter); end
   endtask

   task automatic test_underflow();
      do_reset();
      sample_valid = 1; sample_left = 16'h5A5A; sample_right = 16'hA5A5;
      step();
      sample_valid = 0; pkt_request = 1;
      step();
      step();
      step();
      step();
      pkt_request = 0;
      checks++; if (underflow_count !== 16'd3) begin errors++;
         $display("FAIL underflow_count: got %0d expected 3", underflow_count); end
      checks++; if (frame_counter !== 8'd1) begin errors++;
         $display("FAIL underflow_frame: got %0d expected 1", frame_counter); end
      checks++; if (pkt_valid !== 1'b0 || audio_sample_word[0] !== 24'h5A5A00) begin errors++;
         $display("FAIL underflow_output: got v=%0b %h expected v=0 5a5a00", pkt_valid,
                  audio_sample_word[0]); end
      sample_valid = 1; pkt_request = 1; sample_left = 16'h0777;
      step();
      sample_valid = 0; pkt_request = 0;
      checks++; if (underflow_count !== 16'd4 || pkt_valid !== 1'b1) begin errors++;
         $display("FAIL push_into_empty: got uf=%0d v=%0b expected uf=4 v=1", underflow_count,
                  pkt_valid); end
      checks++; if (audio_sample_word[0] !== 24'h077700 || frame_counter !== 8'd1) begin
         errors++;
         $display("FAIL push_into_empty_data: got %h frame=%0d expected 077700 frame=1",
                  audio_sample_word[0], frame_counter); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] el;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         sample_valid = 1; sample_left = 16'(i * 257 + 3); sample_right = ~16'(i * 257 + 3);
         step();
      end
      for (int i = 4; i < 104; i++) begin
         sample_left = 16'(i * 257 + 3); sample_right = ~16'(i * 257 + 3); pkt_request = 1;
         el = 16'((i - 4) * 257 + 3);
         checks++; if (sample_ready !== 1'b1 || audio_sample_word[0] !== {el, 8'h00}
                       || audio_sample_word[1] !== {~el, 8'h00}) begin errors++;
            $display("FAIL b2b[%0d]: got rdy=%0b %h expected rdy=1 %h%h", i, sample_ready,
                     audio_sample_word, {~el, 8'h00}, {el, 8'h00}); end
         step();
      end
      sample_valid = 0;
      for (int k = 100; k < 104; k++) begin
         el = 16'(k * 257 + 3);
         checks++; if (pkt_valid !== 1'b1 || audio_sample_word[0] !== {el, 8'h00}) begin
            errors++;
            $display("FAIL b2b_drain[%0d]: got v=%0b %h expected v=1 %h", k, pkt_valid,
                     audio_sample_word[0], {el, 8'h00}); end
         step();
      end
      pkt_request = 0;
      checks++; if (pkt_valid !== 1'b0) begin errors++;
         $display("FAIL b2b_occupancy: got %0b expected 0", pkt_valid); end
   endtask

   task automatic test_width24();
      logic [23:0] el;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         v24 = 1; l24 = 24'(i * 66051 + 8388609); r24 = ~24'(i * 66051 + 8388609);
         step();
      end
      for (int i = 4; i < 104; i++) begin
         l24 = 24'(i * 66051 + 8388609); r24 = ~24'(i * 66051 + 8388609); req24 = 1;
         el = 24'((i - 4) * 66051 + 8388609);
         checks++; if (ready24 !== 1'b1 || word24[0] !== el || word24[1] !== ~el) begin
            errors++;
            $display("FAIL w24[%0d]: got rdy=%0b %h expected rdy=1 %h%h", i, ready24, word24,
                     ~el, el); end
         step();
      end
      v24 = 0;
      for (int k = 100; k < 104; k++) begin
         el = 24'(k * 66051 + 8388609);
         checks++; if (pv24 !== 1'b1 || word24[0] !== el) begin errors++;
            $display("FAIL w24_drain[%0d]: got v=%0b %h expected v=1 %h", k, pv24, word24[0],
                     el); end
         step();
      end
      req24 = 0;
      checks++; if (pv24 !== 1'b0 || frame24 !== 8'd104) begin errors++;
         $display("FAIL w24_end: got v=%0b frame=%0d expected v=0 frame=104", pv24, frame24); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      sample_valid = 1; sample_left = 16'd0; sample_right = 16'd0;
      step();
      for (int i = 1; i <= 81; i++) begin
         sample_left = 16'(i); sample_right = 16'(i);
         pkt_request = (i <= 77);
         step();
      end
      sample_valid = 0; pkt_request = 0;
      checks++; if (frame_counter !== 8'd77 || pkt_valid !== 1'b1) begin errors++;
         $display("FAIL mid_setup: got frame=%0d v=%0b expected frame=77 v=1", frame_counter,
                  pkt_valid); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (pkt_valid !== 1'b0 || sample_ready !== 1'b0) begin errors++;
         $display("FAIL mid_reset_outputs: got v=%0b rdy=%0b expected v=0 rdy=0", pkt_valid,
                  sample_ready); end
      checks++; if (frame_counter !== 8'd0) begin errors++;
         $display("FAIL mid_reset_frame: got %0d expected 0", frame_counter); end
      step();
      step();
      reset_n = 1'b1;
      step();
      sample_valid = 1; sample_left = 16'hBEEF; sample_right = 16'hCAFE;
      step();
      sample_valid = 0;
      checks++; if (pkt_valid !== 1'b1 || frame_counter !== 8'd0
                    || audio_sample_word[0] !== 24'hBEEF00) begin errors++;
         $display("FAIL mid_first_after: got v=%0b frame=%0d %h expected v=1 frame=0 beef00",
                  pkt_valid, frame_counter, audio_sample_word[0]); end
      pkt_request = 1;
      step();
      pkt_request = 0;
      checks++; if (pkt_valid !== 1'b0 || frame_counter !== 8'd1) begin errors++;
         $display("FAIL mid_flushed: got v=%0b frame=%0d expected v=0 frame=1", pkt_valid,
                  frame_counter); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_stream();
      test_underflow();
      test_back_to_back();
      test_width24();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
